// File: rtl/mux2_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef logic src_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/mux2_arbiter_pick.sv
// Combinational two-way round-robin picker; an active lock pins the winner to lock_src.
module mux2_arbiter_pick
  import mux2_arbiter_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  src_t ptr,
  input  logic lock,
  input  src_t lock_src,
  output src_t winner,
  output logic any
);

  always_comb begin
    winner = 1'b0;
    any    = 1'b0;
    if (lock) begin
      // While locked the other requester is ignored, even if the owner is idle.
      winner = lock_src;
      any    = lock_src ? valid1 : valid0;
    end else begin
      any = valid0 | valid1;
      if (valid0 && valid1) begin
        winner = ptr;
      end else begin
        winner = valid1;
      end
    end
  end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin 2:1 mux arbiter with a registered output stage.
// Define MUX2_ARBITER_LOCK_EN to add d0_last/d1_last and burst locking.
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d0,
  input  logic             d0_valid,
  output logic             d0_ready,
  input  logic [WIDTH-1:0] d1,
  input  logic             d1_valid,
  output logic             d1_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             s
`ifdef MUX2_ARBITER_LOCK_EN
  ,
  input  logic             d0_last,
  input  logic             d1_last
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  src_t             s_q, s_d;
  src_t             ptr_q, ptr_d;
  logic             load;
  logic             grant;
  logic             any;
  src_t             winner;
  logic             lock_active;
  src_t             lock_owner;

`ifdef MUX2_ARBITER_LOCK_EN
  logic lock_q, lock_d;
  src_t lock_src_q, lock_src_d;
  logic last_sel;

  assign lock_active = lock_q;
  assign lock_owner  = lock_src_q;
  assign last_sel    = winner ? d1_last : d0_last;
`else
  assign lock_active = 1'b0;
  assign lock_owner  = 1'b0;
`endif

  mux2_arbiter_pick u_pick (
    .valid0   (d0_valid),
    .valid1   (d1_valid),
    .ptr      (ptr_q),
    .lock     (lock_active),
    .lock_src (lock_owner),
    .winner   (winner),
    .any      (any)
  );

  assign load = (state_q == EMPTY) | y_ready;
  // Gating with reset_n keeps both readies low for the whole reset pulse.
  assign grant    = load & any & reset_n;
  assign d0_ready = grant & (winner == 1'b0);
  assign d1_ready = grant & (winner == 1'b1);

  assign y       = y_q;
  assign y_valid = (state_q == FULL);
  assign s       = s_q;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
`ifdef MUX2_ARBITER_LOCK_EN
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
`endif
    if (grant) begin
      y_d     = winner ? d1 : d0;
      s_d     = winner;
      state_d = FULL;
`ifdef MUX2_ARBITER_LOCK_EN
      // Priority only rotates once a burst is complete.
      if (last_sel) begin
        lock_d = 1'b0;
        ptr_d  = ~winner;
      end else begin
        lock_d     = 1'b1;
        lock_src_d = winner;
      end
`else
      ptr_d = ~winner;
`endif
    end else if (load) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      y_q     <= '0;
      s_q     <= 1'b0;
      ptr_q   <= 1'b0;
`ifdef MUX2_ARBITER_LOCK_EN
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
`ifdef MUX2_ARBITER_LOCK_EN
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
`endif
    end
  end

endmodule
